// File: rtl/regfile_pkg.sv
// Shared sizing defaults and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned RD_PORTS = 2;
  localparam int unsigned WR_PORTS = 2;

  function automatic int unsigned regfile_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  typedef logic [regfile_addr_w(NREGS)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue reserves a destination, writeback releases it,
// and a pipeline flush clears everything.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned depth_p       = NREGS,
  parameter int unsigned write_ports_p = WR_PORTS,
  parameter int unsigned zero_reg_p    = 1,
  localparam int unsigned AW           = regfile_addr_w(depth_p)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [write_ports_p-1:0]         wr_en_i,
  input  logic [write_ports_p-1:0][AW-1:0] wr_addr_i,
  input  logic                            rsv_en_i,
  input  logic [AW-1:0]                   rsv_addr_i,
  input  logic                            flush_i,
  output logic [depth_p-1:0]              busy_vec_o
);

  logic [depth_p-1:0] r_busy;
  logic [depth_p-1:0] w_busy_nxt;

  // Releases are applied before the reservation so a younger producer's
  // reservation wins over a same-cycle writeback to the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush_i) begin
      w_busy_nxt = '0;
    end else begin
      for (int unsigned w = 0; w < write_ports_p; w++) begin
        if (wr_en_i[w]) w_busy_nxt[wr_addr_i[w]] = 1'b0;
      end
      if (rsv_en_i) w_busy_nxt[rsv_addr_i] = 1'b1;
    end
    if (zero_reg_p != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_busy <= '0;
    else         r_busy <= w_busy_nxt;
  end

  assign busy_vec_o = r_busy;

endmodule

// File: rtl/multiport_register_file.sv
// N-read / M-write register file with optional x0 hardwiring, write-to-read
// bypass and an integrated busy scoreboard for hazard detection.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned width_p       = XLEN,
  parameter int unsigned depth_p       = NREGS,
  parameter int unsigned read_ports_p  = RD_PORTS,
  parameter int unsigned write_ports_p = WR_PORTS,
  parameter int unsigned zero_reg_p    = 1,
  parameter int unsigned bypass_p      = 1,
  localparam int unsigned AW           = regfile_addr_w(depth_p)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [read_ports_p-1:0][AW-1:0]       rd_addr_i,
  output logic [read_ports_p-1:0][width_p-1:0]  rd_data_o,
  output logic [read_ports_p-1:0]               rd_busy_o,
  input  logic [write_ports_p-1:0]              wr_en_i,
  input  logic [write_ports_p-1:0][AW-1:0]      wr_addr_i,
  input  logic [write_ports_p-1:0][width_p-1:0] wr_data_i,
  input  logic                                 rsv_en_i,
  input  logic [AW-1:0]                        rsv_addr_i,
  input  logic                                 flush_i,
  output logic [depth_p-1:0]                   busy_vec_o
);

  logic [width_p-1:0]                  r_regs [depth_p];
  logic [depth_p-1:0]                  w_busy_vec;
  logic [read_ports_p-1:0][width_p-1:0] w_rd_data;
  logic [read_ports_p-1:0]              w_rd_busy;

  regfile_scoreboard #(
    .depth_p      (depth_p),
    .write_ports_p(write_ports_p),
    .zero_reg_p   (zero_reg_p)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .rsv_en_i  (rsv_en_i),
    .rsv_addr_i(rsv_addr_i),
    .flush_i   (flush_i),
    .busy_vec_o(w_busy_vec)
  );

  // Ascending port order: the last non-blocking assignment wins, giving the
  // highest-index port priority on address conflicts.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned r = 0; r < depth_p; r++) r_regs[r] <= '0;
    end else begin
      for (int unsigned w = 0; w < write_ports_p; w++) begin
        if (wr_en_i[w] && !(zero_reg_p != 0 && wr_addr_i[w] == '0))
          r_regs[wr_addr_i[w]] <= wr_data_i[w];
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < read_ports_p; p++) begin
      w_rd_data[p] = r_regs[rd_addr_i[p]];
      w_rd_busy[p] = w_busy_vec[rd_addr_i[p]];
      if (bypass_p != 0) begin
        for (int unsigned w = 0; w < write_ports_p; w++) begin
          if (wr_en_i[w] && wr_addr_i[w] == rd_addr_i[p]) begin
            w_rd_data[p] = wr_data_i[w];
            w_rd_busy[p] = rsv_en_i && (rsv_addr_i == rd_addr_i[p]);
          end
        end
      end
      if (zero_reg_p != 0 && rd_addr_i[p] == '0) begin
        w_rd_data[p] = '0;
        w_rd_busy[p] = 1'b0;
      end
    end
  end

  assign rd_data_o  = w_rd_data;
  assign rd_busy_o  = w_rd_busy;
  assign busy_vec_o = w_busy_vec;

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: directed vector table plus randomized
// traffic against a behavioural model, on a bypass and a non-bypass instance.
module tb_multiport_register_file;
  import regfile_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [NR-1:0][AW-1:0]  rd_addr;
  logic [NR-1:0][W-1:0]   rd_data_a, rd_data_b;
  logic [NR-1:0]          rd_busy_a, rd_busy_b;
  logic [NW-1:0]          wr_en;
  logic [NW-1:0][AW-1:0]  wr_addr;
  logic [NW-1:0][W-1:0]   wr_data;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic                   flush;
  logic [D-1:0]           busy_a, busy_b;

  multiport_register_file #(
    .width_p(W), .depth_p(D), .read_ports_p(NR), .write_ports_p(NW),
    .zero_reg_p(1), .bypass_p(1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
    .rd_busy_o(rd_busy_a), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_vec_o(busy_a)
  );

  multiport_register_file #(
    .width_p(W), .depth_p(D), .read_ports_p(NR), .write_ports_p(NW),
    .zero_reg_p(1), .bypass_p(0)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .rd_busy_o(rd_busy_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_vec_o(busy_b)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_regs [D];
  bit           m_busy [D];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Expected read result from the architectural rules.
  task automatic model_read(input bit byp, input int a, output logic [31:0] d, output bit b);
    int hit;
    hit = -1;
    for (int w = 0; w < NW; w++)
      if (wr_en[w] && int'(wr_addr[w]) == a) hit = w;
    if (a == 0) begin
      d = '0; b = 1'b0;
    end else if (byp && hit >= 0) begin
      d = wr_data[hit];
      b = rsv_en && int'(rsv_addr) == a;
    end else begin
      d = m_regs[a]; b = m_busy[a];
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < D; r++) begin
      m_regs[r] = '0; m_busy[r] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit written;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int r = 1; r < D; r++) begin
      written = 1'b0;
      for (int w = 0; w < NW; w++)
        if (wr_en[w] && int'(wr_addr[w]) == r) begin
          m_regs[r] = wr_data[w]; written = 1'b1;
        end
      if (flush)                                m_busy[r] = 1'b0;
      else if (rsv_en && int'(rsv_addr) == r)   m_busy[r] = 1'b1;
      else if (written)                         m_busy[r] = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] d;
    bit          b;
    logic [D-1:0] bv;
    for (int p = 0; p < NR; p++) begin
      model_read(1'b1, int'(rd_addr[p]), d, b);
      chk($sformatf("%s byp data%0d", tag, p), rd_data_a[p], d);
      chk($sformatf("%s byp busy%0d", tag, p), {31'd0, rd_busy_a[p]}, {31'd0, b});
      model_read(1'b0, int'(rd_addr[p]), d, b);
      chk($sformatf("%s nobyp data%0d", tag, p), rd_data_b[p], d);
      chk($sformatf("%s nobyp busy%0d", tag, p), {31'd0, rd_busy_b[p]}, {31'd0, b});
    end
    for (int r = 0; r < D; r++) bv[r] = m_busy[r];
    chk({tag, " byp busy_vec"}, busy_a, bv);
    chk({tag, " nobyp busy_vec"}, busy_b, bv);
  endtask

  // Inputs are set after a falling edge; outputs are sampled 1 time unit later.
  task automatic settle_check_advance(input string tag);
    #1;
    check_model(tag);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    bit          rstn;
    bit [1:0]    we;
    bit [4:0]    wa0;
    bit [31:0]   wd0;
    bit [4:0]    wa1;
    bit [31:0]   wd1;
    bit          rsv;
    bit [4:0]    rsa;
    bit          fl;
    bit [4:0]    ra0;
    bit [4:0]    ra1;
    bit [31:0]   ed0;
    bit          eb0;
    bit [31:0]   ed1;
    bit          eb1;
    bit [31:0]   ebv;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1, 2'b01, 5, 32'hDEADBEEF, 0, 0,      0, 0, 0,  5, 0,  32'hDEADBEEF, 0, 0, 0, 0};
    tbl[1]  = '{0, 2'b10, 0, 0, 6, 32'h55,            0, 0, 0,  5, 0,  32'hDEADBEEF, 0, 0, 0, 0};
    tbl[2]  = '{1, 2'b00, 0, 0, 0, 0,                 0, 0, 0,  5, 6,  0, 0, 0, 0, 0};
    tbl[3]  = '{1, 2'b11, 7, 32'h11, 7, 32'h22,       0, 0, 0,  7, 7,  32'h22, 0, 32'h22, 0, 0};
    tbl[4]  = '{1, 2'b10, 0, 0, 3, 32'hABCD,          0, 0, 0,  3, 7,  32'hABCD, 0, 32'h22, 0, 0};
    tbl[5]  = '{1, 2'b01, 0, 32'hFFFFFFFF, 0, 0,      1, 0, 0,  0, 3,  0, 0, 32'hABCD, 0, 0};
    tbl[6]  = '{1, 2'b00, 0, 0, 0, 0,                 1, 9, 0,  0, 9,  0, 0, 0, 0, 0};
    tbl[7]  = '{1, 2'b00, 0, 0, 0, 0,                 0, 0, 0,  9, 9,  0, 1, 0, 1, 32'h200};
    tbl[8]  = '{1, 2'b01, 9, 32'h99, 0, 0,            0, 0, 0,  9, 2,  32'h99, 0, 0, 0, 32'h200};
    tbl[9]  = '{1, 2'b10, 0, 0, 9, 32'h77,            1, 9, 0,  9, 5,  32'h77, 1, 0, 0, 0};
    tbl[10] = '{1, 2'b00, 0, 0, 0, 0,                 0, 0, 0,  9, 0,  32'h77, 1, 0, 0, 32'h200};
    tbl[11] = '{1, 2'b00, 0, 0, 0, 0,                 1, 4, 0,  4, 9,  0, 0, 32'h77, 1, 32'h200};
    tbl[12] = '{1, 2'b00, 0, 0, 0, 0,                 1, 6, 0,  4, 6,  0, 1, 0, 0, 32'h210};
    tbl[13] = '{1, 2'b00, 0, 0, 0, 0,                 1, 8, 0,  6, 8,  0, 1, 0, 0, 32'h250};
    tbl[14] = '{1, 2'b01, 12, 32'h1234, 0, 0,         1, 10, 1, 10, 12, 0, 0, 32'h1234, 0, 32'h350};
    tbl[15] = '{1, 2'b00, 0, 0, 0, 0,                 0, 0, 0,  8, 12, 0, 0, 32'h1234, 0, 0};

    rst_n = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();

    rst_n = 1'b1; rd_addr[0] = 5'd5; rd_addr[1] = 5'd31;
    #1;
    chk("reset data0", rd_data_a[0], 32'h0);
    chk("reset data1", rd_data_a[1], 32'h0);
    chk("reset busy_vec", busy_a, 32'h0);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      rst_n      = tbl[i].rstn;
      wr_en      = tbl[i].we;
      wr_addr[0] = tbl[i].wa0; wr_data[0] = tbl[i].wd0;
      wr_addr[1] = tbl[i].wa1; wr_data[1] = tbl[i].wd1;
      rsv_en     = tbl[i].rsv; rsv_addr = tbl[i].rsa;
      flush      = tbl[i].fl;
      rd_addr[0] = tbl[i].ra0; rd_addr[1] = tbl[i].ra1;
      #1;
      chk($sformatf("vec%0d data0", i), rd_data_a[0], tbl[i].ed0);
      chk($sformatf("vec%0d busy0", i), {31'd0, rd_busy_a[0]}, {31'd0, tbl[i].eb0});
      chk($sformatf("vec%0d data1", i), rd_data_a[1], tbl[i].ed1);
      chk($sformatf("vec%0d busy1", i), {31'd0, rd_busy_a[1]}, {31'd0, tbl[i].eb1});
      chk($sformatf("vec%0d busy_vec", i), busy_a, tbl[i].ebv);
      settle_check_advance($sformatf("vec%0d model", i));
    end

    for (int n = 0; n < 3000; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 3) != 0);
      rst_n  = ($urandom_range(0, 199) != 0);
      flush  = ($urandom_range(0, 24) == 0);
      rsv_en = $urandom_range(0, 1) != 0;
      rsv_addr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, D - 1));
      for (int w = 0; w < NW; w++) begin
        wr_en[w]   = $urandom_range(0, 2) != 0;
        wr_addr[w] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, D - 1));
        wr_data[w] = $urandom;
      end
      for (int p = 0; p < NR; p++) begin
        if ($urandom_range(0, 2) == 0) rd_addr[p] = wr_addr[$urandom_range(0, NW - 1)];
        else rd_addr[p] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, D - 1));
      end
      settle_check_advance($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
